// File: rtl/fft_pkg.sv
// Shared FFT helpers: default widths, output saturation and twiddle ROM generation.
package fft_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned TW_W_DEF   = 16;

    // Fixed-point fraction bits used while evaluating sin/cos at elaboration.
    localparam int unsigned ROM_FRAC = 28;
    // pi in Q(ROM_FRAC).
    localparam longint      PI_Q     = 64'sd843314857;

    // Clamp x to the signed range of a w-bit word.
    function automatic longint sat_fn(input longint x, input int unsigned w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Twiddle coefficient for index k of an N=2^log2n FFT, Q1.(tw_w-2),
    // re = round(cos(2*pi*k/N)), im = round(-sin(2*pi*k/N)), ties away from zero.
    // Angles above pi/2 fold back into the first quadrant so the Taylor series
    // converges quickly and the fixed-point products stay inside 64 bits.
    function automatic longint tw_coef(input int unsigned k, input int unsigned log2n,
                                       input int unsigned tw_w, input bit is_im);
        int unsigned quarter;
        int unsigned kk;
        bit          neg_cos;
        longint      x;
        longint      x2;
        longint      t;
        longint      s;
        longint      c;
        longint      v;
        longint      r;
        quarter = 32'd1 << (log2n - 2);
        neg_cos = (k > quarter);
        kk      = neg_cos ? ((32'd1 << (log2n - 1)) - k) : k;
        x       = (PI_Q * longint'(kk)) >>> (log2n - 1);
        x2      = (x * x) >>> ROM_FRAC;
        t = x;
        s = x;
        for (int n = 1; n <= 12; n++) begin
            t = -((t * x2) >>> ROM_FRAC) / longint'((2 * n) * (2 * n + 1));
            s = s + t;
        end
        t = longint'(1) <<< ROM_FRAC;
        c = t;
        for (int n = 1; n <= 12; n++) begin
            t = -((t * x2) >>> ROM_FRAC) / longint'((2 * n - 1) * (2 * n));
            c = c + t;
        end
        v = is_im ? -s : (neg_cos ? -c : c);
        if (v >= 0) begin
            r = ((v <<< (tw_w - 2)) + (longint'(1) <<< (ROM_FRAC - 1))) >>> ROM_FRAC;
        end else begin
            r = -((((-v) <<< (tw_w - 2)) + (longint'(1) <<< (ROM_FRAC - 1))) >>> ROM_FRAC);
        end
        return r;
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle factor ROM: contents fixed at elaboration, registered read with enable.
module twiddle_rom import fft_pkg::*; #(
    parameter int unsigned LOG2N = 3,
    parameter int unsigned TW_W  = TW_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [LOG2N-2:0]       k,
    output logic signed [TW_W-1:0] w_re,
    output logic signed [TW_W-1:0] w_im
);

    localparam int unsigned DEPTH = 1 << (LOG2N - 1);

    logic signed [TW_W-1:0] rom_re [DEPTH];
    logic signed [TW_W-1:0] rom_im [DEPTH];
    logic signed [TW_W-1:0] w_re_q, w_re_d;
    logic signed [TW_W-1:0] w_im_q, w_im_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic signed [TW_W-1:0] RE = TW_W'(tw_coef(i, LOG2N, TW_W, 1'b0));
        localparam logic signed [TW_W-1:0] IM = TW_W'(tw_coef(i, LOG2N, TW_W, 1'b1));
        assign rom_re[i] = RE;
        assign rom_im[i] = IM;
    end

    // Read port: load a new coefficient only when the pipeline advances.
    always_comb begin
        w_re_d = w_re_q;
        w_im_d = w_im_q;
        if (en) begin
            w_re_d = rom_re[k];
            w_im_d = rom_im[k];
        end
    end

    // Read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_re_q <= '0;
            w_im_q <= '0;
        end else begin
            w_re_q <= w_re_d;
            w_im_q <= w_im_d;
        end
    end

    assign w_re = w_re_q;
    assign w_im = w_im_q;

endmodule

// File: rtl/radix2_bfly_pipe.sv
// Three-stage radix-2 DIT butterfly: out_a = A + W*B, out_b = A - W*B.
module radix2_bfly_pipe import fft_pkg::*; #(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LOG2N  = 3,
    parameter int unsigned TW_W   = TW_W_DEF,
    parameter int unsigned SCALE  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LOG2N-2:0]         in_k,
    input  logic signed [DATA_W-1:0] in_a_re,
    input  logic signed [DATA_W-1:0] in_a_im,
    input  logic signed [DATA_W-1:0] in_b_re,
    input  logic signed [DATA_W-1:0] in_b_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_a_re,
    output logic signed [DATA_W-1:0] out_a_im,
    output logic signed [DATA_W-1:0] out_b_re,
    output logic signed [DATA_W-1:0] out_b_im,
    output logic                     out_ovf,
    input  logic                     ovf_clr,
    output logic                     ovf_sticky
);

    localparam int unsigned PW  = DATA_W + TW_W + 1;
    localparam int unsigned WBW = DATA_W + 2;
    localparam int unsigned SW  = DATA_W + 3;
    localparam int unsigned SH  = TW_W - 2;
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (SH - 1);

    logic                     v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] a1_re_q, a1_re_d, a1_im_q, a1_im_d;
    logic signed [DATA_W-1:0] b1_re_q, b1_re_d, b1_im_q, b1_im_d;
    logic signed [DATA_W-1:0] a2_re_q, a2_re_d, a2_im_q, a2_im_d;
    logic signed [WBW-1:0]    wb_re_q, wb_re_d, wb_im_q, wb_im_d;
    logic signed [DATA_W-1:0] res_q [4];
    logic signed [DATA_W-1:0] res_d [4];
    logic                     out_ovf_q, out_ovf_d, ovf_sticky_q, ovf_sticky_d;
    logic signed [TW_W-1:0]   w_re, w_im;
    logic                     adv_c;
    logic signed [PW-1:0]     prod_re_c, prod_im_c;
    logic signed [SW-1:0]     lane_c [4];
    logic signed [DATA_W-1:0] sat_c [4];
    logic                     ovf_c;

    // The whole pipeline moves together; it freezes only when a result is held.
    assign adv_c    = out_ready | ~out_valid_q;
    assign in_ready = adv_c;

    twiddle_rom #(
        .LOG2N (LOG2N),
        .TW_W  (TW_W)
    ) u_twiddle_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (adv_c),
        .k    (in_k),
        .w_re (w_re),
        .w_im (w_im)
    );

    // Datapath: full-precision complex multiply (S2) and add/sub, scale, saturate (S3).
    always_comb begin
        logic signed [SW-1:0] scaled;
        longint               sat_l;
        prod_re_c = PW'(b1_re_q) * PW'(w_re) - PW'(b1_im_q) * PW'(w_im);
        prod_im_c = PW'(b1_re_q) * PW'(w_im) + PW'(b1_im_q) * PW'(w_re);
        lane_c[0] = SW'(a2_re_q) + SW'(wb_re_q);
        lane_c[1] = SW'(a2_im_q) + SW'(wb_im_q);
        lane_c[2] = SW'(a2_re_q) - SW'(wb_re_q);
        lane_c[3] = SW'(a2_im_q) - SW'(wb_im_q);
        ovf_c     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scaled = lane_c[i];
            if (SCALE != 0) begin
                scaled = (lane_c[i] + SW'(1)) >>> 1;
            end
            sat_l    = sat_fn(longint'(scaled), DATA_W);
            sat_c[i] = DATA_W'(sat_l);
            if (sat_l != longint'(scaled)) begin
                ovf_c = 1'b1;
            end
        end
    end

    // Next-state: every stage holds unless the pipeline advances; bubbles leave outputs alone.
    always_comb begin
        v1_d         = v1_q;
        a1_re_d      = a1_re_q;
        a1_im_d      = a1_im_q;
        b1_re_d      = b1_re_q;
        b1_im_d      = b1_im_q;
        v2_d         = v2_q;
        a2_re_d      = a2_re_q;
        a2_im_d      = a2_im_q;
        wb_re_d      = wb_re_q;
        wb_im_d      = wb_im_q;
        out_valid_d  = out_valid_q;
        out_ovf_d    = out_ovf_q;
        res_d        = res_q;
        ovf_sticky_d = ovf_sticky_q | (out_valid_q & out_ready & out_ovf_q);
        if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
        if (adv_c) begin
            v1_d        = in_valid;
            a1_re_d     = in_a_re;
            a1_im_d     = in_a_im;
            b1_re_d     = in_b_re;
            b1_im_d     = in_b_im;
            v2_d        = v1_q;
            a2_re_d     = a1_re_q;
            a2_im_d     = a1_im_q;
            wb_re_d     = WBW'((prod_re_c + RND) >>> SH);
            wb_im_d     = WBW'((prod_im_c + RND) >>> SH);
            out_valid_d = v2_q;
            if (v2_q) begin
                res_d     = sat_c;
                out_ovf_d = ovf_c;
            end
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q         <= 1'b0;
            a1_re_q      <= '0;
            a1_im_q      <= '0;
            b1_re_q      <= '0;
            b1_im_q      <= '0;
            v2_q         <= 1'b0;
            a2_re_q      <= '0;
            a2_im_q      <= '0;
            wb_re_q      <= '0;
            wb_im_q      <= '0;
            out_valid_q  <= 1'b0;
            out_ovf_q    <= 1'b0;
            ovf_sticky_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            v1_q         <= v1_d;
            a1_re_q      <= a1_re_d;
            a1_im_q      <= a1_im_d;
            b1_re_q      <= b1_re_d;
            b1_im_q      <= b1_im_d;
            v2_q         <= v2_d;
            a2_re_q      <= a2_re_d;
            a2_im_q      <= a2_im_d;
            wb_re_q      <= wb_re_d;
            wb_im_q      <= wb_im_d;
            out_valid_q  <= out_valid_d;
            out_ovf_q    <= out_ovf_d;
            ovf_sticky_q <= ovf_sticky_d;
            res_q        <= res_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_a_re   = res_q[0];
    assign out_a_im   = res_q[1];
    assign out_b_re   = res_q[2];
    assign out_b_im   = res_q[3];
    assign out_ovf    = out_ovf_q;
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_radix2_bfly_pipe.sv
// Scoreboard bench for radix2_bfly_pipe: SCALE=0 and SCALE=1 instances fed in lockstep.
module tb_radix2_bfly_pipe;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned LOG2N  = 3;
    localparam int unsigned TW_W   = 16;

    typedef struct packed {
        logic signed [15:0] a_re;
        logic signed [15:0] a_im;
        logic signed [15:0] b_re;
        logic signed [15:0] b_im;
        logic               ovf;
    } res_t;

    typedef struct packed {
        res_t s0;
        res_t s1;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready, ovf_clr;
    logic [LOG2N-2:0] in_k;
    logic signed [DATA_W-1:0] in_a_re, in_a_im, in_b_re, in_b_im;
    logic in_ready0, in_ready1;
    logic o0_valid, o0_ovf, o0_sticky, o1_valid, o1_ovf, o1_sticky;
    logic signed [DATA_W-1:0] o0_a_re, o0_a_im, o0_b_re, o0_b_im;
    logic signed [DATA_W-1:0] o1_a_re, o1_a_im, o1_b_re, o1_b_im;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    bit   hs_seen = 1'b0;
    bit   hs_ovf0 = 1'b0;
    bit   hs_ovf1 = 1'b0;
    bit   exp_sticky0 = 1'b0;
    bit   exp_sticky1 = 1'b0;

    always #5 clk = ~clk;

    radix2_bfly_pipe #(.DATA_W(DATA_W), .LOG2N(LOG2N), .TW_W(TW_W), .SCALE(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_k(in_k),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .out_valid(o0_valid), .out_ready(out_ready),
        .out_a_re(o0_a_re), .out_a_im(o0_a_im), .out_b_re(o0_b_re), .out_b_im(o0_b_im),
        .out_ovf(o0_ovf), .ovf_clr(ovf_clr), .ovf_sticky(o0_sticky)
    );

    radix2_bfly_pipe #(.DATA_W(DATA_W), .LOG2N(LOG2N), .TW_W(TW_W), .SCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_k(in_k),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .out_valid(o1_valid), .out_ready(out_ready),
        .out_a_re(o1_a_re), .out_a_im(o1_a_im), .out_b_re(o1_b_re), .out_b_im(o1_b_im),
        .out_ovf(o1_ovf), .ovf_clr(ovf_clr), .ovf_sticky(o1_sticky)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic longint fdiv(input longint n, input longint d);
        longint r;
        r = n / d;
        if ((n % d != 0) && (n < 0)) r = r - 1;
        return r;
    endfunction

    function automatic longint rnd_real(input real x);
        if (x >= 0.0) return longint'($rtoi($floor(x + 0.5)));
        return -longint'($rtoi($floor(-x + 0.5)));
    endfunction

    function automatic longint clamp16(input longint x, inout bit ovf);
        if (x > 32767) begin ovf = 1'b1; return 32767; end
        if (x < -32768) begin ovf = 1'b1; return -32768; end
        return x;
    endfunction

    // Reference butterfly from the arithmetic definition (real-valued twiddles, floor division).
    function automatic res_t model(input longint ar, ai, br, bi, input int k, input bit scale);
        real    ang;
        longint wr, wi, wbr, wbi;
        longint v[4];
        bit     ovf;
        res_t   r;
        ang = 2.0 * 3.14159265358979323846 * real'(k) / 8.0;
        wr  = rnd_real($cos(ang) * 16384.0);
        wi  = rnd_real(-$sin(ang) * 16384.0);
        wbr = fdiv(br * wr - bi * wi + 8192, 16384);
        wbi = fdiv(br * wi + bi * wr + 8192, 16384);
        v[0] = ar + wbr; v[1] = ai + wbi; v[2] = ar - wbr; v[3] = ai - wbi;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (scale) v[i] = fdiv(v[i] + 1, 2);
            v[i] = clamp16(v[i], ovf);
        end
        r.a_re = 16'(v[0]); r.a_im = 16'(v[1]); r.b_re = 16'(v[2]); r.b_im = 16'(v[3]);
        r.ovf  = ovf;
        return r;
    endfunction

    // Scoreboard push on every accepted input.
    always @(posedge clk) begin
        if (!rst && in_valid && in_ready0) begin
            q.push_back('{s0: model(longint'(in_a_re), longint'(in_a_im), longint'(in_b_re),
                                    longint'(in_b_im), int'(in_k), 1'b0),
                          s1: model(longint'(in_a_re), longint'(in_a_im), longint'(in_b_re),
                                    longint'(in_b_im), int'(in_k), 1'b1)});
        end
    end

    // Sticky flag reference, driven by completed transfers observed by the monitor.
    always @(posedge clk) begin
        if (rst || ovf_clr) begin
            exp_sticky0 = 1'b0;
            exp_sticky1 = 1'b0;
        end else if (hs_seen) begin
            if (hs_ovf0) exp_sticky0 = 1'b1;
            if (hs_ovf1) exp_sticky1 = 1'b1;
        end
    end

    // Monitor: presented result must match queue head every cycle it is shown; pop on transfer.
    always @(negedge clk) begin
        exp_t e;
        hs_seen = 1'b0;
        if (!rst) begin
            if (o0_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = q[0];
                    chk("s0_a_re", o0_a_re, e.s0.a_re);
                    chk("s0_a_im", o0_a_im, e.s0.a_im);
                    chk("s0_b_re", o0_b_re, e.s0.b_re);
                    chk("s0_b_im", o0_b_im, e.s0.b_im);
                    chk("s0_ovf", o0_ovf, e.s0.ovf);
                    chk("s1_valid", o1_valid, 1);
                    chk("s1_a_re", o1_a_re, e.s1.a_re);
                    chk("s1_a_im", o1_a_im, e.s1.a_im);
                    chk("s1_b_re", o1_b_re, e.s1.b_re);
                    chk("s1_b_im", o1_b_im, e.s1.b_im);
                    chk("s1_ovf", o1_ovf, e.s1.ovf);
                    if (out_ready) begin
                        hs_seen = 1'b1;
                        hs_ovf0 = e.s0.ovf;
                        hs_ovf1 = e.s1.ovf;
                        void'(q.pop_front());
                    end
                end
            end
            chk("sticky0", o0_sticky, exp_sticky0);
            chk("sticky1", o1_sticky, exp_sticky1);
        end
    end

    task automatic drive(input int ar, ai, br, bi, k);
        in_a_re = 16'(ar); in_a_im = 16'(ai); in_b_re = 16'(br); in_b_im = 16'(bi);
        in_k    = 2'(k);
    endtask

    // Present one input until accepted; returns at accept edge + #1.
    task automatic send(input int ar, ai, br, bi, k);
        bit acc;
        drive(ar, ai, br, bi, k);
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(posedge clk);
            acc = in_ready0;
        end
        #1;
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int  lat;
        bit  found;
        int  n;
        int  vcnt;
        bit  acc;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o0_valid, 0);
        chk("rst_ovf", o0_ovf, 0);
        chk("rst_sticky", o0_sticky, 0);
        chk("rst_a_re", o0_a_re, 0);
        chk("rst_b_im", o0_b_im, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", in_ready0, 1);
        @(posedge clk); #1;

        // Basic butterfly and latency.
        send(100, 0, 50, 0, 0);
        lat = 0; found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (o0_valid) found = 1'b1;
        end
        chk("latency", lat, 3);
        idle(3);

        // Twiddles -j and (1-j)/sqrt2.
        send(100, 0, 50, 0, 2);
        send(0, 0, 10000, 0, 1);
        idle(6);

        // Saturation, sticky set then cleared.
        send(32000, 0, 32000, 0, 0);
        idle(6);
        chk("sticky_set", o0_sticky, 1);
        chk("sticky_scaled", o1_sticky, 0);
        ovf_clr = 1'b1;
        idle(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", o0_sticky, 0);
        @(posedge clk); #1;

        // Eight back-to-back inputs with out_ready low for cycles 2..7.
        n = 0;
        for (int c = 0; c < 100 && n < 8; c++) begin
            out_ready = !(c >= 2 && c <= 7);
            drive(1000 * n - 3000, 200 * n, 3000 - 500 * n, -100 * n, n % 4);
            in_valid = 1'b1;
            if (c == 5) begin
                @(negedge clk);
                chk("stall_in_ready", in_ready0, 0);
                chk("stall_out_valid", o0_valid, 1);
            end
            @(posedge clk);
            acc = in_ready0;
            if (acc) n++;
            #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stall_all_sent", n, 8);
        idle(8);

        // Reset while three results are in flight.
        send(32000, 0, 32000, 0, 0);
        idle(5);
        chk("sticky_before_rst", o0_sticky, 1);
        drive(1, 2, 3, 4, 1);
        in_valid = 1'b1;
        idle(3);
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        idle(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", o0_valid, 0);
        chk("rst_mid_sticky", o0_sticky, 0);
        chk("rst_mid_ready", in_ready0, 1);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o0_valid) vcnt++;
        end
        chk("no_stale", vcnt, 0);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure and occasional clears.
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 1) == 0) begin
                drive(int'(16'($urandom)), int'(16'($urandom)), int'(16'($urandom)),
                      int'(16'($urandom)), int'($urandom_range(0, 3)));
            end else begin
                drive(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                      int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                      int'($urandom_range(0, 3)));
            end
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            ovf_clr   = ($urandom_range(0, 19) == 0);
            idle(1);
        end
        in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        for (int i = 0; i < 200 && q.size() != 0; i++) idle(1);
        idle(2);
        chk("drain_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/radix2_bfly_pipe.md
RADIX2_BFLY_PIPE -- requirements
Module: radix2_bfly_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed two's-complement width of every real/imag data port.
REQ-002 SHALL have parameter LOG2N, default 3: log2 of FFT size N; legal range 2..10.
REQ-003 SHALL have parameter TW_W, default 16: signed twiddle width, format Q1.(TW_W-2), so 1.0 = 2^(TW_W-2).
REQ-004 SHALL have parameter SCALE, default 0: 1 = divide both outputs by 2; 0 = saturate, no scaling.
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk  in  1  rising-edge clock.
REQ-006 SHALL have port rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports in_valid in 1 and in_ready out 1: input handshake.
REQ-008 SHALL have port in_k  in  LOG2N-1  twiddle index k, W = exp(-j*2*pi*k/N).
REQ-009 SHALL have ports in_a_re, in_a_im, in_b_re, in_b_im  in  DATA_W each: operands A and B.
REQ-010 SHALL have ports out_valid out 1 and out_ready in 1: output handshake.
REQ-011 SHALL have ports out_a_re, out_a_im, out_b_re, out_b_im  out  DATA_W each: results.
REQ-012 SHALL have port out_ovf  out  1: saturation occurred on any of the four outputs of the current result.
REQ-013 SHALL have ports ovf_clr in 1 and ovf_sticky out 1: sticky OR of out_ovf over accepted results, cleared by ovf_clr.

Function
REQ-014 SHALL compute out_a = A + W*B and out_b = A - W*B.
REQ-015 SHALL take W from a twiddle ROM: re = round(cos(2*pi*k/N)*2^(TW_W-2)), im = round(-sin(2*pi*k/N)*2^(TW_W-2)).
REQ-016 SHALL hold WB at full precision, add 2^(TW_W-3), arithmetic-shift right by TW_W-2, and keep DATA_W+2 bits.
REQ-017 SHALL form A +/- WB at DATA_W+3 bits with no intermediate wrap.
REQ-018 SHALL, with SCALE=1, add 1 and arithmetic-shift right by 1 before the saturation check.
REQ-019 SHALL clamp each output to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set out_ovf when any output was clamped.
REQ-020 SHALL use a 3-stage pipeline: S1 = ROM read and operand register; S2 = complex multiply and round; S3 = add/sub, scale and saturate.
REQ-021 SHALL present a result 3 cycles after acceptance when out_ready stays high, sustaining one result per cycle.
REQ-022 SHALL accept a transfer only when in_valid and in_ready are both high, and complete a result only when out_valid and out_ready are both high.
REQ-023 SHALL drive in_ready = out_ready OR NOT out_valid; when low, the whole pipeline stalls and every stage holds.
REQ-024 SHALL keep the output data, out_ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL carry empty pipeline slots as bubbles with no effect on the outputs or on ovf_sticky.
REQ-026 SHALL give ovf_clr priority over a simultaneous set; a set in the same cycle is discarded.
REQ-027 SHALL preserve input order with no drops and no duplicates under any stall pattern.

Reset
REQ-028 SHALL, while rst is high, clear all stage valid bits, out_valid, out_ovf and ovf_sticky to 0, and all output data to 0.
REQ-029 SHALL discard in-flight data on rst mid-operation, with in_ready = 1 in the first cycle after rst deasserts.

Structure
REQ-030 SHALL place DATA_W/TW_W defaults, the saturate function and the ROM-generation function in shared package fft_pkg.
REQ-031 SHALL instantiate one sub-module twiddle_rom (parameters LOG2N, TW_W), synchronous read, 1-cycle latency, ROM contents built at elaboration.

Verification (DATA_W=16, LOG2N=3, TW_W=16)
REQ-032 SHALL cover: SCALE=0, A=(100,0), B=(50,0), k=0 -> out_a=(150,0), out_b=(50,0), out_ovf=0, out_valid exactly 3 cycles after accept.
REQ-033 SHALL cover: A=(100,0), B=(50,0), k=2 (W=-j) -> out_a=(100,-50), out_b=(100,50).
REQ-034 SHALL cover: SCALE=0, A=(32000,0), B=(32000,0), k=0 -> out_a=(32767,0), out_b=(0,0), out_ovf=1, ovf_sticky=1 until ovf_clr; with SCALE=1 -> out_a=(32000,0), out_ovf=0.
REQ-035 SHALL cover: continuous in_valid for 8 inputs with out_ready low for cycles 2-7 -> in_ready drops once 3 results are held, output stays stable, all 8 results emerge in order.
REQ-036 SHALL cover: rst pulsed while 3 results are in flight -> out_valid=0 next cycle, no stale result ever emitted, ovf_sticky=0.
REQ-037 SHALL cover: k=1 with B=(10000,0) -> W=(11585,-11585), WB=(7071,-7071) after rounding, so A=0 gives out_a=(7071,-7071), out_b=(-7071,7071).
